// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit. One bit per cycle: shift-add multiply
// and restoring divide on operand magnitudes, with sign fix-up on the final step.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q, neg_r;
    logic [2*XLEN-1:0] p_q, p_step, prod;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   res_q, res_fin, res_spec;
    logic [TAG_W-1:0]  tag_q;

    logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg, special, last;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;
    assign out_tag   = tag_q;

    assign accept = in_valid && in_ready && !flush;
    assign is_div = funct3[2];
    assign last   = (state == CALC) && (cnt_q == CNT_W'(1));

    // Operand signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed.
    always_comb begin
        a_sgn = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn = is_div ? !funct3[0] : !funct3[1];
        a_neg = a_sgn && rs1[XLEN-1];
        b_neg = b_sgn && rs2[XLEN-1];
        a_mag = a_neg ? -rs1 : rs1;
        b_mag = b_neg ? -rs2 : rs2;
    end

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        special  = 1'b0;
        res_spec = '0;
        if (is_div && rs2 == '0) begin
            special  = 1'b1;
            res_spec = funct3[1] ? rs1 : ONES;
        end else if (is_div && !funct3[0] && rs1 == MOST_NEG && rs2 == ONES) begin
            special  = 1'b1;
            res_spec = funct3[1] ? '0 : rs1;
        end
    end

    // p_q = {hi, lo}: multiply keeps partial sum in hi and multiplier in lo;
    // divide keeps partial remainder in hi and dividend/quotient bits in lo.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
        div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN])
                p_step = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
            else
                p_step = {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end else begin
            p_step = {mul_sum, p_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -p_step : p_step;
        quo  = neg_q ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
        rem  = neg_r ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
        if (op_q[2])
            res_fin = op_q[1] ? rem : quo;
        else
            res_fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            p_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= funct3;
                b_q   <= is_div ? b_mag : a_mag;
                p_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                cnt_q <= special ? '0 : CNT_W'(XLEN);
                tag_q <= rd_tag;
                if (special) res_q <= res_spec;
            end else if (state == CALC) begin
                p_q   <= p_step;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last) res_q <= res_fin;
            end
            if (flush) cnt_q <= '0;
        end
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 Parameter TAG_W, default 5, destination-register tag width.
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1  input  XLEN  operand A (dividend / multiplicand).
REQ-009 rs2  input  XLEN  operand B (divisor / multiplier).
REQ-010 rd_tag  input  TAG_W  destination tag, returned unchanged with the result.
REQ-011 flush  input  1  squash the in-flight op (pipeline kill).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  op result.
REQ-015 out_tag  output  TAG_W  tag of the completed op.
REQ-016 busy  output  1  high in CALC or DONE.

Function
REQ-017 FSM states: IDLE, CALC, DONE.
REQ-018 Accept = in_valid && in_ready && !flush; on accept, latch funct3, operand magnitudes, result-sign flags and rd_tag.
REQ-019 IDLE -> CALC on a normal accept; IDLE -> DONE on a special-case accept (REQ-024, REQ-025).
REQ-020 CALC runs exactly XLEN cycles on a down-counter of width clog2(XLEN)+1, processing one bit per cycle: shift-add multiply, restoring divide on magnitudes.
REQ-021 CALC -> DONE when the counter expires; out_valid rises in the XLEN+1th cycle after the accept edge.
REQ-022 Multiply forms the full 2*XLEN product with sign correction.
- Signedness: MUL/MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
- MUL returns the low XLEN bits; the others return the high XLEN bits.
REQ-023 Divide: DIV/REM are signed, DIVU/REMU unsigned.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-024 Divide by zero: quotient = all ones; remainder = rs1 unchanged; completes via IDLE -> DONE with out_valid one cycle after accept.
REQ-025 Signed overflow (DIV/REM with rs1 = most-negative and rs2 = all ones): quotient = rs1; remainder = 0; out_valid one cycle after accept.
REQ-026 DONE holds out_valid, result and out_tag stable until out_valid && out_ready; next state is IDLE. No accept occurs in that same cycle, since in_ready is low in DONE.
REQ-027 flush in any state forces IDLE next cycle, drops out_valid, discards the op; flush dominates a same-cycle accept and a same-cycle out_ready.
REQ-028 result and out_tag are don't-care while out_valid is low; they are not required to hold stale values.

Reset
REQ-029 With rst_n low at a rising edge, the next state is IDLE: out_valid = 0, busy = 0, result = 0, out_tag = 0, counter = 0; in_ready is high from the first cycle after reset release.
REQ-030 Reset asserted mid-CALC or in DONE aborts the op with no result emitted; it behaves identically to REQ-029.

Verification (XLEN=32, out_ready held high unless stated)
REQ-031 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after the accept edge, out_tag equals rd_tag.
REQ-032 rs1=rs2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-033 Division cases:
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
- REM with the same operands -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5, both one cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-034 Back-pressure: out_ready held low 5 cycles after out_valid -> result, out_tag and out_valid stable throughout, and in_ready stays low. Raising out_ready -> IDLE next cycle.
REQ-035 Abort cases:
- flush on CALC cycle 10 -> out_valid never rises for that op; in_ready high the next cycle; a new MUL 3*4 then returns 12.
- rst_n low for one cycle mid-CALC -> the same abort behaviour, with all outputs at reset values.
REQ-036 flush and in_valid asserted together in IDLE -> no accept; busy stays 0.
